// File: rtl/x_uart_frame_pkg.sv
// Shared types and constants for the UART command deframer.
// Optional checksum byte enabled by defining X_UART_FRAME_RX_CSUM_EN.
package x_uart_frame_pkg;

`ifdef X_UART_FRAME_RX_CSUM_EN
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_CMD  = 3'd1,
      ST_ADDR = 3'd2,
      ST_DHI  = 3'd3,
      ST_DLO  = 3'd4,
      ST_CSUM = 3'd5
   } state_e;

   localparam int unsigned FRAME_LEN = 6;

   // Frame checksum: XOR of every byte after the sync byte.
   function automatic logic [7:0] frame_csum(input logic [7:0] cmd,
                                             input logic [7:0] addr,
                                             input logic [7:0] dhi,
                                             input logic [7:0] dlo);
      return cmd ^ addr ^ dhi ^ dlo;
   endfunction
`else
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_CMD  = 3'd1,
      ST_ADDR = 3'd2,
      ST_DHI  = 3'd3,
      ST_DLO  = 3'd4
   } state_e;

   localparam int unsigned FRAME_LEN = 5;
`endif

   localparam logic [7:0] SYNC_BYTE = 8'hA5;
   localparam logic [7:0] CMD_WR    = 8'h01;
   localparam logic [7:0] CMD_RD    = 8'h02;

endpackage

// File: rtl/x_uart_frame_timer.sv
// Inter-byte gap timer. Counts idle cycles while a frame is in progress and
// raises a registered one-cycle o_expire as the count reaches
// TIMEOUT_CYCLES-1, so the consumer acts on it at the TIMEOUT_CYCLES-th
// idle cycle.
module x_uart_frame_timer #(
   parameter int unsigned TIMEOUT_CYCLES = 100000
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_run,
   input  logic i_kick,
   output logic o_expire
);

   localparam int unsigned      CNT_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] PRE   = CNT_W'(TIMEOUT_CYCLES - 2);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             expire_q, expire_d;

   // Next count: clear when idle or on a byte, otherwise count up and saturate.
   always_comb begin
      cnt_d    = cnt_q;
      expire_d = 1'b0;
      if (!i_run || i_kick) begin
         cnt_d = '0;
      end else begin
         if (cnt_q != LAST) cnt_d = cnt_q + CNT_W'(1);
         expire_d = (cnt_q == PRE);
      end
   end

   // Counter and expiry pulse registers.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         cnt_q    <= '0;
         expire_q <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         expire_q <= expire_d;
      end
   end

   assign o_expire = expire_q;

endmodule

// File: rtl/x_uart_frame_rx.sv
// Byte-to-command deframer: SYNC CMD ADDR DATA_HI DATA_LO [CSUM].
// Define X_UART_FRAME_RX_CSUM_EN to require the trailing XOR checksum byte.
// Held outputs only change on a good frame; drops pulse o_err.
module x_uart_frame_rx
   import x_uart_frame_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 100000
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_valid,
   input  logic [7:0]  i_data,
   output logic        o_cmd_valid,
   output logic        o_cmd_wr,
   output logic [7:0]  o_addr,
   output logic [15:0] o_wdata,
   output logic        o_err
);

   state_e      state_q, state_d;
   logic [7:0]  cmd_sh_q, cmd_sh_d;
   logic [7:0]  addr_sh_q, addr_sh_d;
   logic [7:0]  dhi_sh_q, dhi_sh_d;
`ifdef X_UART_FRAME_RX_CSUM_EN
   logic [7:0]  dlo_sh_q, dlo_sh_d;
`endif
   logic        cmd_valid_q, cmd_valid_d;
   logic        err_q, err_d;
   logic        cmd_wr_q, cmd_wr_d;
   logic [7:0]  addr_q, addr_d;
   logic [15:0] wdata_q, wdata_d;
   logic        expire;

   x_uart_frame_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timer (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_run    (state_q != ST_IDLE),
      .i_kick   (i_valid),
      .o_expire (expire)
   );

   // Frame FSM next state; a byte in the expiry cycle takes priority over timeout.
   always_comb begin
      state_d     = state_q;
      cmd_sh_d    = cmd_sh_q;
      addr_sh_d   = addr_sh_q;
      dhi_sh_d    = dhi_sh_q;
`ifdef X_UART_FRAME_RX_CSUM_EN
      dlo_sh_d    = dlo_sh_q;
`endif
      cmd_valid_d = 1'b0;
      err_d       = 1'b0;
      cmd_wr_d    = cmd_wr_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      if (i_valid) begin
         case (state_q)
            ST_IDLE: if (i_data == SYNC_BYTE) state_d = ST_CMD;
            ST_CMD: begin
               if (i_data == CMD_WR || i_data == CMD_RD) begin
                  cmd_sh_d = i_data;
                  state_d  = ST_ADDR;
               end else begin
                  err_d   = 1'b1;
                  state_d = ST_IDLE;
               end
            end
            ST_ADDR: begin
               addr_sh_d = i_data;
               state_d   = ST_DHI;
            end
            ST_DHI: begin
               dhi_sh_d = i_data;
               state_d  = ST_DLO;
            end
`ifdef X_UART_FRAME_RX_CSUM_EN
            ST_DLO: begin
               dlo_sh_d = i_data;
               state_d  = ST_CSUM;
            end
            ST_CSUM: begin
               if (i_data == frame_csum(cmd_sh_q, addr_sh_q, dhi_sh_q, dlo_sh_q)) begin
                  cmd_valid_d = 1'b1;
                  cmd_wr_d    = (cmd_sh_q == CMD_WR);
                  addr_d      = addr_sh_q;
                  wdata_d     = {dhi_sh_q, dlo_sh_q};
               end else begin
                  err_d = 1'b1;
               end
               state_d = ST_IDLE;
            end
`else
            ST_DLO: begin
               cmd_valid_d = 1'b1;
               cmd_wr_d    = (cmd_sh_q == CMD_WR);
               addr_d      = addr_sh_q;
               wdata_d     = {dhi_sh_q, i_data};
               state_d     = ST_IDLE;
            end
`endif
            default: state_d = ST_IDLE;
         endcase
      end else if (expire && state_q != ST_IDLE) begin
         err_d   = 1'b1;
         state_d = ST_IDLE;
      end
   end

   // State, shadow and output registers; reset aborts any frame silently.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q     <= ST_IDLE;
         cmd_sh_q    <= '0;
         addr_sh_q   <= '0;
         dhi_sh_q    <= '0;
`ifdef X_UART_FRAME_RX_CSUM_EN
         dlo_sh_q    <= '0;
`endif
         cmd_valid_q <= 1'b0;
         err_q       <= 1'b0;
         cmd_wr_q    <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         cmd_sh_q    <= cmd_sh_d;
         addr_sh_q   <= addr_sh_d;
         dhi_sh_q    <= dhi_sh_d;
`ifdef X_UART_FRAME_RX_CSUM_EN
         dlo_sh_q    <= dlo_sh_d;
`endif
         cmd_valid_q <= cmd_valid_d;
         err_q       <= err_d;
         cmd_wr_q    <= cmd_wr_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
      end
   end

   assign o_cmd_valid = cmd_valid_q;
   assign o_err       = err_q;
   assign o_cmd_wr    = cmd_wr_q;
   assign o_addr      = addr_q;
   assign o_wdata     = wdata_q;

endmodule

// File: tb/tb_x_uart_frame_rx.sv
// Directed bench for x_uart_frame_rx with TIMEOUT_CYCLES=16.
// Inputs change on the falling edge; outputs are checked on the falling edge
// after the rising edge that produced them.
module tb_x_uart_frame_rx;
   import x_uart_frame_pkg::*;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_valid;
   logic [7:0]  i_data;
   logic        o_cmd_valid;
   logic        o_cmd_wr;
   logic [7:0]  o_addr;
   logic [15:0] o_wdata;
   logic        o_err;

   int n_asserts = 0;
   int n_fail    = 0;

   x_uart_frame_rx #(
      .TIMEOUT_CYCLES(16)
   ) dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_valid     (i_valid),
      .i_data      (i_data),
      .o_cmd_valid (o_cmd_valid),
      .o_cmd_wr    (o_cmd_wr),
      .o_addr      (o_addr),
      .o_wdata     (o_wdata),
      .o_err       (o_err)
   );

   always #5 i_clk = ~i_clk;

   task automatic step(input logic v, input logic [7:0] d);
      @(negedge i_clk);
      i_valid = v;
      i_data  = d;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic cv, input logic err,
                          input logic wr, input logic [7:0] addr, input logic [15:0] wdata);
      chk({tag, ".cmd_valid"}, 32'(o_cmd_valid), 32'(cv));
      chk({tag, ".err"},       32'(o_err),       32'(err));
      chk({tag, ".cmd_wr"},    32'(o_cmd_wr),    32'(wr));
      chk({tag, ".addr"},      32'(o_addr),      32'(addr));
      chk({tag, ".wdata"},     32'(o_wdata),     32'(wdata));
   endtask

   task automatic send_frame(input logic [7:0] cmd, input logic [7:0] addr,
                             input logic [7:0] dhi, input logic [7:0] dlo);
      logic [7:0] b [6];
      b[0] = 8'hA5;
      b[1] = cmd;
      b[2] = addr;
      b[3] = dhi;
      b[4] = dlo;
      b[5] = cmd ^ addr ^ dhi ^ dlo;
      for (int i = 0; i < FRAME_LEN; i++) step(1'b1, b[i]);
   endtask

   // Command and error strobes must never coincide.
   always @(negedge i_clk) begin
      if (!i_rst) begin
         n_asserts++;
         assert (!(o_cmd_valid && o_err)) else begin
            n_fail++;
            $error("FAIL excl: observed cmd_valid=%0b err=%0b expected not both", o_cmd_valid, o_err);
         end
      end
   end

   initial begin
      i_rst   = 1'b1;
      i_valid = 1'b0;
      i_data  = 8'h00;
      repeat (3) @(negedge i_clk);
      chk_out("reset", 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
      i_rst = 1'b0;

      // Good write: A5 01 10 12 34 [37]
      send_frame(8'h01, 8'h10, 8'h12, 8'h34);
      step(1'b0, 8'h00);
      chk_out("wr1", 1'b1, 1'b0, 1'b1, 8'h10, 16'h1234);
      step(1'b0, 8'h00);
      chk("wr1.pulse_end", 32'(o_cmd_valid), 32'd0);

`ifdef X_UART_FRAME_RX_CSUM_EN
      // Bad checksum: A5 02 20 00 FF 00 (correct would be DD)
      step(1'b1, 8'hA5);
      step(1'b1, 8'h02);
      step(1'b1, 8'h20);
      step(1'b1, 8'h00);
      step(1'b1, 8'hFF);
      step(1'b1, 8'h00);
      step(1'b0, 8'h00);
      chk_out("badcsum", 1'b0, 1'b1, 1'b1, 8'h10, 16'h1234);
      step(1'b0, 8'h00);
      chk("badcsum.pulse_end", 32'(o_err), 32'd0);
`endif

      // Good read: A5 02 20 00 FF [DD]
      send_frame(8'h02, 8'h20, 8'h00, 8'hFF);
      step(1'b0, 8'h00);
      chk_out("rd1", 1'b1, 1'b0, 1'b0, 8'h20, 16'h00FF);

      // Noise bytes ignored, then a bad command code
      step(1'b1, 8'h00);
      step(1'b1, 8'hFF);
      chk("noise.err0", 32'(o_err), 32'd0);
      step(1'b1, 8'h5A);
      chk("noise.err1", 32'(o_err), 32'd0);
      step(1'b1, 8'hA5);
      chk("noise.err2", 32'(o_err), 32'd0);
      step(1'b1, 8'h07);
      chk("badcmd.before", 32'(o_err), 32'd0);
      step(1'b0, 8'h00);
      chk_out("badcmd", 1'b0, 1'b1, 1'b0, 8'h20, 16'h00FF);
      step(1'b0, 8'h00);
      chk("badcmd.pulse_end", 32'(o_err), 32'd0);

      // Timeout: A5 01 then silence; error lands on the 16th idle edge
      step(1'b1, 8'hA5);
      step(1'b1, 8'h01);
      for (int k = 0; k < 16; k++) begin
         step(1'b0, 8'h00);
         chk("tmo.quiet", 32'(o_err), 32'd0);
      end
      step(1'b0, 8'h00);
      chk_out("tmo", 1'b0, 1'b1, 1'b0, 8'h20, 16'h00FF);
      step(1'b0, 8'h00);
      chk("tmo.pulse_end", 32'(o_err), 32'd0);
      send_frame(8'h01, 8'h55, 8'hAB, 8'hCD);
      step(1'b0, 8'h00);
      chk_out("after_tmo", 1'b1, 1'b0, 1'b1, 8'h55, 16'hABCD);

      // Byte arrives on the expiry edge: frame continues
      step(1'b1, 8'hA5);
      step(1'b1, 8'h01);
      for (int k = 0; k < 15; k++) step(1'b0, 8'h00);
      step(1'b1, 8'h66);
      step(1'b1, 8'h77);
      chk("collide.err", 32'(o_err), 32'd0);
      step(1'b1, 8'h88);
`ifdef X_UART_FRAME_RX_CSUM_EN
      step(1'b1, 8'h98);
`endif
      step(1'b0, 8'h00);
      chk_out("collide", 1'b1, 1'b0, 1'b1, 8'h66, 16'h7788);

      // Back-to-back frames: read then write with no gap
      send_frame(8'h02, 8'h20, 8'h00, 8'hFF);
      step(1'b1, 8'hA5);
      chk_out("b2b.first", 1'b1, 1'b0, 1'b0, 8'h20, 16'h00FF);
      step(1'b1, 8'h01);
      chk("b2b.gap", 32'(o_cmd_valid), 32'd0);
      step(1'b1, 8'h10);
      step(1'b1, 8'h12);
      step(1'b1, 8'h34);
`ifdef X_UART_FRAME_RX_CSUM_EN
      step(1'b1, 8'h37);
`endif
      step(1'b0, 8'h00);
      chk_out("b2b.second", 1'b1, 1'b0, 1'b1, 8'h10, 16'h1234);

      // Reset mid-frame
      step(1'b1, 8'hA5);
      step(1'b1, 8'h02);
      step(1'b1, 8'h42);
      @(negedge i_clk);
      i_rst   = 1'b1;
      i_valid = 1'b0;
      #1;
      chk_out("midrst", 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
      @(negedge i_clk);
      i_rst = 1'b0;
      step(1'b1, 8'h11);
      step(1'b1, 8'h22);
      step(1'b0, 8'h00);
      chk_out("postrst", 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
      send_frame(8'h02, 8'h7F, 8'h00, 8'h01);
      step(1'b0, 8'h00);
      chk_out("recover", 1'b1, 1'b0, 1'b0, 8'h7F, 16'h0001);

      step(1'b0, 8'h00);
      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
